// File: rtl/nios_cpu_debug_ocimem_ctrl_pkg.sv
// nios_cpu_debug_ocimem_ctrl_pkg
// Shared definitions for the debug monitor RAM controller.
//   state_e   - controller FSM states
//   JDO_*     - bit positions of the fields carried in the 38-bit jdo word
package nios_cpu_debug_ocimem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DBG_RD  = 3'd1,
    ST_DBG_CAP = 3'd2,
    ST_DBG_WR  = 3'd3,
    ST_CPU_RD  = 3'd4,
    ST_CPU_RDY = 3'd5,
    ST_CPU_WR  = 3'd6
  } state_e;

  // jdo[34] doubles as the read flag of an address load and the MSB of
  // write data; which meaning applies depends on the pulse that is high.
  localparam int JDO_RDFLAG   = 34;
  localparam int JDO_ADDR_HI  = 33;
  localparam int JDO_ADDR_LO  = 26;
  localparam int JDO_WDATA_HI = 34;
  localparam int JDO_WDATA_LO = 3;

endpackage

// File: rtl/nios_cpu_debug_ocimem_ctrl.sv
// nios_cpu_debug_ocimem_ctrl
// Executes JTAG debugger reads/writes into the debug monitor RAM through an
// auto-incrementing address register, and shares that single-port RAM with
// a CPU-side Avalon slave. The debugger always wins arbitration.
//
// Ports:
//   clk, reset                        clock, async active-high reset
//   jdo, take_action_ocimem_a/b,
//   take_no_action_ocimem_a           debug command word and command pulses
//   MonDReg, MonAReg                  last debug read data, debug address
//   monitor_ready, monitor_error      command done, sticky dropped-command flag
//   ram_addr/wdata/rd/wr, ram_rdata   monitor RAM port (rdata 1 cycle after rd)
//   avs_*                             CPU Avalon slave
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | accepts a debug command, else a CPU request
// ST_DBG_RD  | debug read strobe on the RAM
// ST_DBG_CAP | capture RAM data into MonDReg, bump MonAReg
// ST_DBG_WR  | debug write strobe on the RAM, bump MonAReg
// ST_CPU_RD  | CPU read strobe on the RAM
// ST_CPU_RDY | CPU read data presented, waitrequest released
// ST_CPU_WR  | CPU write strobe on the RAM, waitrequest released
module nios_cpu_debug_ocimem_ctrl
  import nios_cpu_debug_ocimem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [DATA_W-1:0] MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_rd,
  output logic              ram_wr,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest
);

  state_e            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;

  logic [ADDR_W-1:0] jdo_addr;
  logic [DATA_W-1:0] jdo_wdata;
  logic              idle;
  logic              dbg_any;
  logic              acc_load;
  logic              acc_wr;
  logic              acc_rdnext;
  logic              acc_rd;
  logic              dbg_drop;
  logic              unused_jdo;

  assign jdo_addr  = ADDR_W'(jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
  assign jdo_wdata = DATA_W'(jdo[JDO_WDATA_HI:JDO_WDATA_LO]);
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign idle    = (state == ST_IDLE);
  assign dbg_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // Only the highest-priority pulse is executed, and only from IDLE.
  assign acc_load   = idle & take_action_ocimem_a;
  assign acc_wr     = idle & ~take_action_ocimem_a & take_action_ocimem_b;
  assign acc_rdnext = idle & ~take_action_ocimem_a & ~take_action_ocimem_b
                      & take_no_action_ocimem_a;
  assign acc_rd     = acc_rdnext | (acc_load & jdo[JDO_RDFLAG]);

  // Everything that arrived but was not executed counts as dropped.
  assign dbg_drop = idle ? ((take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                            | (take_action_ocimem_b & take_no_action_ocimem_a))
                         : dbg_any;

  // RAM port decoded purely from registered state/address/data.
  assign ram_rd    = (state == ST_DBG_RD) || (state == ST_CPU_RD);
  assign ram_wr    = (state == ST_DBG_WR) || (state == ST_CPU_WR);
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  assign avs_waitrequest = !((state == ST_CPU_WR) || (state == ST_CPU_RDY));
  // RAM data only becomes valid in CPU_RDY, so it is forwarded there and
  // held in cpu_rdata_q afterwards.
  assign avs_readdata = (state == ST_CPU_RDY) ? ram_rdata : cpu_rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      cpu_rdata_q   <= '0;
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc_load) begin
            MonAReg <= jdo_addr;
          end
          if (acc_rd) begin
            state         <= ST_DBG_RD;
            addr_q        <= acc_load ? jdo_addr : MonAReg;
            monitor_ready <= 1'b0;
          end else if (acc_wr) begin
            state         <= ST_DBG_WR;
            addr_q        <= MonAReg;
            wdata_q       <= jdo_wdata;
            monitor_ready <= 1'b0;
          end else if (acc_load) begin
            monitor_ready <= 1'b1;
          end else if (!dbg_any && avs_write) begin
            state   <= ST_CPU_WR;
            addr_q  <= avs_address;
            wdata_q <= avs_writedata;
          end else if (!dbg_any && avs_read) begin
            state  <= ST_CPU_RD;
            addr_q <= avs_address;
          end
        end
        ST_DBG_RD: state <= ST_DBG_CAP;
        ST_DBG_CAP: begin
          MonDReg       <= ram_rdata;
          monitor_ready <= 1'b1;
          MonAReg       <= MonAReg + ADDR_W'(1);
          state         <= ST_IDLE;
        end
        ST_DBG_WR: begin
          monitor_ready <= 1'b1;
          MonAReg       <= MonAReg + ADDR_W'(1);
          state         <= ST_IDLE;
        end
        ST_CPU_RD: state <= ST_CPU_RDY;
        ST_CPU_RDY: begin
          cpu_rdata_q <= ram_rdata;
          state       <= ST_IDLE;
        end
        ST_CPU_WR: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase

      // A dropped pulse in the same cycle as an address load still flags.
      if (acc_load) begin
        monitor_error <= 1'b0;
      end
      if (dbg_drop) begin
        monitor_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nios_cpu_debug_ocimem_ctrl.sv
// tb_nios_cpu_debug_ocimem_ctrl
// Directed scenarios plus randomized debug/CPU traffic against a
// transaction-level model (one in-flight access with an age counter).
module tb_nios_cpu_debug_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        monitor_ready, monitor_error;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_rd, ram_wr;
  logic [31:0] ram_rdata;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        avs_waitrequest;

  always #5 clk = ~clk;

  nios_cpu_debug_ocimem_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .MonDReg(MonDReg), .MonAReg(MonAReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_rdata(ram_rdata),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor RAM (synchronous read) ----------------
  function automatic logic [31:0] seed_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    if (i == 16) return 32'hDEADBEEF;
    if (i == 32) return 32'hCAFEF00D;
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  logic [31:0] mem [0:255];
  logic        mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed_word(i);
    end else begin
      if (ram_wr) mem[ram_addr] <= ram_wdata;
      if (ram_rd) ram_rdata <= mem[ram_addr];
    end
  end

  // ---------------- reference model ----------------
  localparam int K_NONE = 0, K_DRD = 1, K_DWR = 2, K_CRD = 3, K_CWR = 4;

  logic [31:0] mm [0:255];
  int          op_kind, op_age;
  logic [7:0]  op_addr;
  logic [31:0] op_data;
  logic [7:0]  m_areg;
  logic [31:0] m_dreg;
  logic        m_ready, m_err;
  logic        e_rd, e_wr, e_wait, e_rvalid;

  function automatic int dur(input int k);
    return (k == K_DWR || k == K_CWR) ? 2 : 3;
  endfunction

  task automatic model_reset();
    op_kind = K_NONE; op_age = 0; op_addr = 8'h00; op_data = 32'h0;
    m_areg = 8'h00; m_dreg = 32'h0; m_ready = 1'b0; m_err = 1'b0;
    e_rd = 1'b0; e_wr = 1'b0; e_wait = 1'b1; e_rvalid = 1'b0;
  endtask

  task automatic start(input int k, input logic [7:0] ad, input logic [31:0] d);
    op_kind = k; op_age = 1; op_addr = ad; op_data = d;
  endtask

  // Consumes the inputs of the cycle ending at this edge and produces the
  // expectations for the following cycle.
  task automatic model_step();
    bit idle, a, b, na;
    logic [7:0] la;
    idle = (op_kind == K_NONE);
    a  = take_action_ocimem_a;
    b  = take_action_ocimem_b;
    na = take_no_action_ocimem_a;
    la = jdo[33:26];
    if (op_kind != K_NONE) begin
      op_age++;
      if (op_age == dur(op_kind)) begin
        if (op_kind == K_DRD) begin
          m_dreg = op_data; m_ready = 1'b1; m_areg = op_addr + 8'd1;
        end else if (op_kind == K_DWR) begin
          m_ready = 1'b1; m_areg = op_addr + 8'd1;
        end
        op_kind = K_NONE;
      end
    end
    if (!idle) begin
      if (a | b | na) m_err = 1'b1;
    end else if (a) begin
      m_areg = la;
      m_err  = b | na;
      if (jdo[34]) begin
        start(K_DRD, la, mm[la]);
        m_ready = 1'b0;
      end else begin
        m_ready = 1'b1;
      end
    end else if (b) begin
      if (na) m_err = 1'b1;
      mm[m_areg] = jdo[34:3];
      start(K_DWR, m_areg, jdo[34:3]);
      m_ready = 1'b0;
    end else if (na) begin
      start(K_DRD, m_areg, mm[m_areg]);
      m_ready = 1'b0;
    end else if (avs_write) begin
      mm[avs_address] = avs_writedata;
      start(K_CWR, avs_address, avs_writedata);
    end else if (avs_read) begin
      start(K_CRD, avs_address, mm[avs_address]);
    end
    e_rd     = (op_kind == K_DRD || op_kind == K_CRD) && op_age == 1;
    e_wr     = (op_kind == K_DWR || op_kind == K_CWR) && op_age == 1;
    e_rvalid = (op_kind == K_CRD) && op_age == 2;
    e_wait   = !(((op_kind == K_CWR) && op_age == 1) || e_rvalid);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ram_rd", 32'(ram_rd), 32'(e_rd));
      chk("ram_wr", 32'(ram_wr), 32'(e_wr));
      chk("avs_waitrequest", 32'(avs_waitrequest), 32'(e_wait));
      chk("MonAReg", 32'(MonAReg), 32'(m_areg));
      chk("MonDReg", MonDReg, m_dreg);
      chk("monitor_ready", 32'(monitor_ready), 32'(m_ready));
      chk("monitor_error", 32'(monitor_error), 32'(m_err));
      if (e_rd || e_wr) chk("ram_addr", 32'(ram_addr), 32'(op_addr));
      if (e_wr) chk("ram_wdata", ram_wdata, op_data);
      if (e_rvalid) chk("avs_readdata", avs_readdata, op_data);
    end
  end

  // One clock: model consumes this cycle's inputs, then pulses clear and a
  // finished CPU request is withdrawn by the master.
  task automatic cycle();
    bit done;
    @(posedge clk);
    done = (avs_read || avs_write) && !e_wait;
    model_step();
    #1;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    if (done) begin
      avs_read  = 1'b0;
      avs_write = 1'b0;
    end
  endtask

  function automatic logic [37:0] mk_load(input logic rd, input logic [7:0] ad);
    logic [37:0] j;
    j = '0;
    j[34] = rd;
    j[33:26] = ad;
    return j;
  endfunction

  function automatic logic [37:0] mk_wr(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    avs_address = 8'h00; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = 32'h0;
    model_reset();
    for (int i = 0; i < 256; i++) mm[i] = seed_word(i);

    @(posedge clk); #1;
    chk("rst_MonDReg", MonDReg, 32'h0);
    chk("rst_MonAReg", 32'(MonAReg), 32'h0);
    chk("rst_ready", 32'(monitor_ready), 32'h0);
    chk("rst_error", 32'(monitor_error), 32'h0);
    chk("rst_ram_rd", 32'(ram_rd), 32'h0);
    chk("rst_ram_wr", 32'(ram_wr), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_avs_readdata", avs_readdata, 32'h0);
    chk("rst_waitrequest", 32'(avs_waitrequest), 32'h1);
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    #2 reset = 1'b0;
    chk_en = 1'b1;

    // Address load with read at 0x10.
    jdo = mk_load(1'b1, 8'h10); take_action_ocimem_a = 1'b1;
    cycle();
    chk("t1_ram_rd", 32'(ram_rd), 32'h1);
    chk("t1_ram_addr", 32'(ram_addr), 32'h10);
    cycle(); cycle();
    chk("t1_MonDReg", MonDReg, 32'hDEADBEEF);
    chk("t1_ready", 32'(monitor_ready), 32'h1);
    chk("t1_MonAReg", 32'(MonAReg), 32'h11);

    // Three writes across the address wrap, then read them back.
    jdo = mk_load(1'b0, 8'hFE); take_action_ocimem_a = 1'b1;
    cycle();
    chk("t2_load_ready", 32'(monitor_ready), 32'h1);
    chk("t2_load_areg", 32'(MonAReg), 32'hFE);
    for (int d = 1; d <= 3; d++) begin
      jdo = mk_wr(32'(d)); take_action_ocimem_b = 1'b1;
      cycle(); cycle();
    end
    chk("t2_areg_wrap", 32'(MonAReg), 32'h01);
    jdo = mk_load(1'b1, 8'hFE); take_action_ocimem_a = 1'b1;
    cycle(); cycle(); cycle();
    chk("t2_rd_fe", MonDReg, 32'h1);
    take_no_action_ocimem_a = 1'b1;
    cycle(); cycle(); cycle();
    chk("t2_rd_ff", MonDReg, 32'h2);
    take_no_action_ocimem_a = 1'b1;
    cycle(); cycle(); cycle();
    chk("t2_rd_00", MonDReg, 32'h3);
    chk("t2_areg_end", 32'(MonAReg), 32'h01);

    // Read-next right behind a write-next is dropped; load clears the error.
    jdo = mk_wr(32'h0000A5A5); take_action_ocimem_b = 1'b1;
    cycle();
    take_no_action_ocimem_a = 1'b1;
    cycle();
    cycle();
    chk("t3_err_set", 32'(monitor_error), 32'h1);
    repeat (4) cycle();
    chk("t3_err_sticky", 32'(monitor_error), 32'h1);
    jdo = mk_load(1'b0, 8'h40); take_action_ocimem_a = 1'b1;
    cycle();
    chk("t3_err_clr", 32'(monitor_error), 32'h0);

    // CPU read colliding with a debug write: debug first.
    avs_address = 8'h20; avs_read = 1'b1;
    jdo = mk_wr(32'h0BADF00D); take_action_ocimem_b = 1'b1;
    cycle();
    chk("t4_dbg_wr", 32'(ram_wr), 32'h1);
    chk("t4_wait_dbg", 32'(avs_waitrequest), 32'h1);
    cycle();
    chk("t4_wait_idle", 32'(avs_waitrequest), 32'h1);
    cycle();
    chk("t4_cpu_rd", 32'(ram_rd), 32'h1);
    chk("t4_cpu_addr", 32'(ram_addr), 32'h20);
    cycle();
    chk("t4_wait_low", 32'(avs_waitrequest), 32'h0);
    chk("t4_rdata", avs_readdata, 32'hCAFEF00D);
    cycle();

    // CPU write then read back at 0x05.
    avs_address = 8'h05; avs_writedata = 32'h12345678; avs_write = 1'b1;
    cycle();
    chk("t5_wr_wait", 32'(avs_waitrequest), 32'h0);
    chk("t5_wr_strobe", 32'(ram_wr), 32'h1);
    cycle();
    avs_read = 1'b1;
    cycle(); cycle();
    chk("t5_rd_wait", 32'(avs_waitrequest), 32'h0);
    chk("t5_rdata", avs_readdata, 32'h12345678);
    chk("t5_ready", 32'(monitor_ready), 32'h1);
    chk("t5_error", 32'(monitor_error), 32'h0);
    cycle();

    // Reset in the middle of a debug read.
    take_no_action_ocimem_a = 1'b1;
    cycle();
    chk("t6_in_rd", 32'(ram_rd), 32'h1);
    #2;
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_rst_rd", 32'(ram_rd), 32'h0);
    chk("t6_rst_areg", 32'(MonAReg), 32'h0);
    chk("t6_rst_ready", 32'(monitor_ready), 32'h0);
    chk("t6_rst_wait", 32'(avs_waitrequest), 32'h1);
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk_en = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    cycle();
    chk("t6_post_addr", 32'(ram_addr), 32'h0);
    chk("t6_post_rd", 32'(ram_rd), 32'h1);
    cycle(); cycle();
    chk("t6_post_dreg", MonDReg, 32'h3);
    chk("t6_post_areg", 32'(MonAReg), 32'h1);

    // Randomized mixed traffic.
    for (int n = 0; n < 4000; n++) begin
      jdo = {6'($urandom), $urandom};
      take_action_ocimem_a    = ($urandom_range(0, 9) == 0);
      take_action_ocimem_b    = ($urandom_range(0, 5) == 0);
      take_no_action_ocimem_a = ($urandom_range(0, 5) == 0);
      if (!avs_read && !avs_write && $urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, 9);
        avs_address   = 8'($urandom);
        avs_writedata = $urandom;
        if (k < 5) avs_read = 1'b1;
        else if (k < 9) avs_write = 1'b1;
        else begin
          avs_read  = 1'b1;
          avs_write = 1'b1;
        end
      end
      cycle();
    end
    repeat (6) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_cpu_debug_ocimem_ctrl.md
# nios_cpu_debug_ocimem_ctrl

Downstream consumer of the debug slave's system-clock outputs (`jdo`, `take_action_ocimem_a/b`, `take_no_action_ocimem_a`). It executes JTAG debugger reads and writes into the on-chip debug monitor RAM with an auto-incrementing address. It returns read data and status (`MonDReg`, `monitor_ready`, `monitor_error`) to the debug slave. It also arbitrates a CPU-side Avalon slave onto the same single-port RAM, and the debugger always has priority.

## Interface
Parameters:
- ADDR_W, 8, RAM word-address width; the address wraps modulo 2^ADDR_W.
- DATA_W, 32, RAM and monitor data width; fixed at 32 because of the `jdo` encoding.

Ports:
- clk  in  1  the single clock; all logic is synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- jdo  in  38  debug data word from the debug slave; stable while any take_* pulse is high.
- take_action_ocimem_a  in  1  one-cycle pulse: address load, with an optional read.
- take_no_action_ocimem_a  in  1  one-cycle pulse: read-next.
- take_action_ocimem_b  in  1  one-cycle pulse: write-next.
- MonDReg  out  32  last data read by the debugger.
- MonAReg  out  ADDR_W  current debug address.
- monitor_ready  out  1  the last debug command has completed.
- monitor_error  out  1  sticky: a command was dropped.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rd  out  1  RAM read strobe.
- ram_wr  out  1  RAM write strobe.
- ram_rdata  in  32  RAM read data, valid 1 cycle after `ram_rd`.
- avs_address  in  ADDR_W  CPU slave address.
- avs_read  in  1  CPU slave read request.
- avs_write  in  1  CPU slave write request.
- avs_writedata  in  32  CPU slave write data.
- avs_readdata  out  32  CPU slave read data.
- avs_waitrequest  out  1  CPU slave stall.

## Operation
Command decode uses jdo bit fields:
- Address load (`take_action_ocimem_a`): MonAReg <= jdo[33:26]. It also clears monitor_error. If jdo[34]=1, a read is issued at the new address.
- Read-next (`take_no_action_ocimem_a`): reads RAM at MonAReg.
- Write-next (`take_action_ocimem_b`): writes jdo[34:3] to RAM at MonAReg.
- Address increment: MonAReg increments by 1 after every completed debug read or write, wrapping from 2^ADDR_W-1 to 0. An address load without a read does not increment.

FSM states: IDLE, DBG_RD, DBG_CAP, DBG_WR, CPU_RD, CPU_RDY, CPU_WR.
- IDLE -> DBG_RD on a read command (load-with-read, or read-next).
- IDLE -> DBG_WR on write-next.
- IDLE -> CPU_RD / CPU_WR on avs_read / avs_write, only if no debug pulse arrives that cycle.
- A pure address load stays in IDLE.
- DBG_RD -> DBG_CAP -> IDLE.
- DBG_WR -> IDLE.
- CPU_RD -> CPU_RDY -> IDLE.
- CPU_WR -> IDLE.

RAM strobes and handshakes:
- RAM strobes are asserted only in DBG_RD, DBG_WR, CPU_RD and CPU_WR.
- ram_addr, ram_wdata, ram_rd and ram_wr are decoded from the registered state and registered addr/data, so they are glitch-free.
- monitor_ready clears the cycle after any debug command is accepted. It sets when DBG_CAP captures MonDReg or DBG_WR completes. A pure address load sets it the next cycle.
- avs_waitrequest is 1 except in CPU_WR and CPU_RDY. avs_readdata = ram_rdata, registered into CPU_RDY.

Boundary conditions:
- Debug pulse while the FSM is not IDLE: the command is dropped and monitor_error is set.
- Two debug pulses in the same cycle: priority is ocimem_a, then ocimem_b, then no_action_a. The lower-priority pulses are dropped and monitor_error is set.
- Debug pulse and CPU request in the same IDLE cycle: debug wins. The CPU holds its request with waitrequest=1 and is served after the FSM returns to IDLE.
- CPU requests never set monitor_error.
- Read and write both asserted on the CPU side: write wins.

## Timing
Reset values:
- MonDReg=0, MonAReg=0, monitor_ready=0, monitor_error=0.
- ram_rd=0, ram_wr=0, ram_addr=0, ram_wdata=0.
- avs_readdata=0, avs_waitrequest=1, state=IDLE.
- Reset asserted mid-operation forces every output to its reset value immediately (asynchronously); the in-flight access is abandoned.

Latencies (debug pulse or CPU request sampled in cycle N):
- Debug read: ram_rd=1 in N+1. MonDReg is valid and monitor_ready=1 from N+3. MonAReg increments at N+3.
- Debug write: ram_wr=1 in N+1. monitor_ready=1 and MonAReg increments from N+2.
- CPU read: ram_rd=1 in N+1. avs_waitrequest=0 with valid avs_readdata in N+2.
- CPU write: ram_wr=1 and avs_waitrequest=0 in N+1.
- Throughput: one access every 2 cycles for writes and every 3 cycles for debug reads.

## Structure
- Shared package contents:
  - state enum.
  - jdo field constants: JDO_RDFLAG=34, JDO_ADDR_HI=33, JDO_ADDR_LO=26, JDO_WDATA_HI=34, JDO_WDATA_LO=3.
- Single module, no sub-module.
- The monitor RAM is instantiated by the parent.

## Test plan
- Address load jdo[33:26]=0x10, jdo[34]=1, RAM[0x10]=0xDEADBEEF -> ram_rd at N+1 with addr 0x10. From N+3: MonDReg=0xDEADBEEF, monitor_ready=1, MonAReg=0x11.
- Three write-next commands with data 1, 2, 3 from MonAReg=0xFE -> RAM[0xFE]=1, RAM[0xFF]=2, RAM[0x00]=3 (wrap-around); MonAReg ends at 0x01.
- Read-next issued 1 cycle after a write-next -> the read is dropped, monitor_error=1. The error stays set until the next address load, which clears it.
- CPU avs_read at 0x20 in the same cycle as a debug write-next -> the debug write completes first. The CPU then gets RAM[0x20] with waitrequest low 2 cycles after the FSM returns to IDLE.
- CPU write 0x12345678 to 0x05, then CPU read 0x05 -> waitrequest low at N+1 for the write. The read returns 0x12345678 at its N+2. monitor_ready and monitor_error are unaffected.
- Reset asserted during DBG_RD -> ram_rd drops asynchronously, MonAReg=0, monitor_ready=0. The first post-reset read-next reads address 0.
